forward_scoreboard: RTL and testbench

- Parametrised successor to the pipeline forward unit.
- Combines a physical-register busy-bit scoreboard, priority forwarding from NUM_FWD result buses, and a HIST_DEPTH-entry write-back history buffer.
- Serves NUM_SRC source operands per cycle, sitting between register-file read and issue/EX in the renamed pipeline.
- Produces per-source data and ready, a global stall, and stall/occupancy statistics.

---
 rtl/forward_scoreboard.sv | 204 ++++++++++++++++++++
 tb/tb_forward_scoreboard.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_scoreboard.sv
// forward_scoreboard
//   Operand readiness and bypass unit for the renamed pipeline. Tracks a busy
//   bit per physical register and keeps a short history of recent
//   write-backs. For every source operand it picks data from the
//   highest-priority match:
//     forwarding buses (0 first) > same-cycle write-back > history
//     (newest first) > register file.
//   It also reports a global stall and running statistics.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_flush             drop all busy bits and history
//   i_alloc_valid/tag   destination allocated by rename
//   i_src_valid/tag     source operands (packed, n at [n*TAG_W +: TAG_W])
//   i_src_rf_data       register-file read data per source
//   i_fwd_*             NUM_FWD result buses (index 0 youngest)
//   i_wb_valid/tag/data final write-back
//   o_src_data/ready    resolved operand per source
//   o_stall             some used source is not ready
//   o_busy_count        number of busy tags
//   o_stall_cycles      saturating count of stalled cycles
module forward_scoreboard #(
    parameter int NUM_PHYS   = 64,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 2,
    parameter int NUM_FWD    = 3,
    parameter int HIST_DEPTH = 4,
    localparam int TAG_W     = $clog2(NUM_PHYS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush,
    input  logic                          i_alloc_valid,
    input  logic [TAG_W-1:0]              i_alloc_tag,
    input  logic [NUM_SRC-1:0]            i_src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]      i_src_tag,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_rf_data,
    input  logic [NUM_FWD-1:0]            i_fwd_valid,
    input  logic [NUM_FWD-1:0]            i_fwd_is_load,
    input  logic [NUM_FWD*TAG_W-1:0]      i_fwd_tag,
    input  logic [NUM_FWD*DATA_WIDTH-1:0] i_fwd_data,
    input  logic                          i_wb_valid,
    input  logic [TAG_W-1:0]              i_wb_tag,
    input  logic [DATA_WIDTH-1:0]         i_wb_data,
    output logic [NUM_SRC*DATA_WIDTH-1:0] o_src_data,
    output logic [NUM_SRC-1:0]            o_src_ready,
    output logic                          o_stall,
    output logic [TAG_W:0]                o_busy_count,
    output logic [15:0]                   o_stall_cycles
);

    logic [NUM_PHYS-1:0]   busy_q, busy_d;
    logic                  hist_valid_q [HIST_DEPTH];
    logic                  hist_valid_d [HIST_DEPTH];
    logic [TAG_W-1:0]      hist_tag_q   [HIST_DEPTH];
    logic [TAG_W-1:0]      hist_tag_d   [HIST_DEPTH];
    logic [DATA_WIDTH-1:0] hist_data_q  [HIST_DEPTH];
    logic [DATA_WIDTH-1:0] hist_data_d  [HIST_DEPTH];
    logic [15:0]           stall_cycles_q, stall_cycles_d;

    logic                  wb_real;
    logic                  alloc_real;

    // Tag 0 is the hard-wired zero register and never enters any state.
    assign wb_real    = i_wb_valid && (i_wb_tag != '0);
    assign alloc_real = i_alloc_valid && (i_alloc_tag != '0);

    // ------------------------------------------------------------------
    // Operand resolution
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]      s_tag;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_rdy;
    logic                  s_hit;

    always_comb begin
        o_src_data  = '0;
        o_src_ready = '0;
        o_stall     = 1'b0;
        s_tag       = '0;
        s_data      = '0;
        s_rdy       = 1'b0;
        s_hit       = 1'b0;
        for (int n = 0; n < NUM_SRC; n++) begin
            s_tag  = i_src_tag[n*TAG_W +: TAG_W];
            s_data = i_src_rf_data[n*DATA_WIDTH +: DATA_WIDTH];
            s_rdy  = ~busy_q[s_tag];
            s_hit  = 1'b0;
            if (s_tag == '0) begin
                s_data = '0;
                s_rdy  = 1'b1;
                s_hit  = 1'b1;
            end
            // A matching load still claims the operand, so an older copy of
            // the same tag further down can never slip past it.
            for (int k = 0; k < NUM_FWD; k++) begin
                if (!s_hit && i_fwd_valid[k] && (i_fwd_tag[k*TAG_W +: TAG_W] == s_tag)) begin
                    s_data = i_fwd_data[k*DATA_WIDTH +: DATA_WIDTH];
                    s_rdy  = ~i_fwd_is_load[k];
                    s_hit  = 1'b1;
                end
            end
            if (!s_hit && i_wb_valid && (i_wb_tag == s_tag)) begin
                s_data = i_wb_data;
                s_rdy  = 1'b1;
                s_hit  = 1'b1;
            end
            // Entry 0 is the newest write-back.
            for (int h = 0; h < HIST_DEPTH; h++) begin
                if (!s_hit && hist_valid_q[h] && (hist_tag_q[h] == s_tag)) begin
                    s_data = hist_data_q[h];
                    s_rdy  = 1'b1;
                    s_hit  = 1'b1;
                end
            end
            if (!i_src_valid[n]) begin
                s_data = i_src_rf_data[n*DATA_WIDTH +: DATA_WIDTH];
                s_rdy  = 1'b1;
            end
            o_src_data[n*DATA_WIDTH +: DATA_WIDTH] = s_data;
            o_src_ready[n] = s_rdy;
            o_stall        = o_stall | (i_src_valid[n] & ~s_rdy);
        end
    end

    // ------------------------------------------------------------------
    // Next-state: busy table, history, statistics
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (wb_real) begin
            busy_d[i_wb_tag] = 1'b0;
        end
        if (alloc_real) begin
            busy_d[i_alloc_tag] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (i_flush) begin
            busy_d = '0;
        end
    end

    always_comb begin
        for (int h = 0; h < HIST_DEPTH; h++) begin
            hist_valid_d[h] = hist_valid_q[h];
            hist_tag_d[h]   = hist_tag_q[h];
            hist_data_d[h]  = hist_data_q[h];
        end
        if (wb_real) begin
            for (int h = HIST_DEPTH - 1; h > 0; h--) begin
                hist_valid_d[h] = hist_valid_q[h-1];
                hist_tag_d[h]   = hist_tag_q[h-1];
                hist_data_d[h]  = hist_data_q[h-1];
            end
            hist_valid_d[0] = 1'b1;
            hist_tag_d[0]   = i_wb_tag;
            hist_data_d[0]  = i_wb_data;
        end
        // Invalidate after the push so a write-back racing a re-allocation
        // of the same tag is never forwarded later.
        for (int h = 0; h < HIST_DEPTH; h++) begin
            if (i_flush || (alloc_real && (hist_tag_d[h] == i_alloc_tag))) begin
                hist_valid_d[h] = 1'b0;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (o_stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_comb begin
        o_busy_count = '0;
        for (int i = 0; i < NUM_PHYS; i++) begin
            o_busy_count = o_busy_count + {{TAG_W{1'b0}}, busy_q[i]};
        end
    end

    assign o_stall_cycles = stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            stall_cycles_q <= '0;
            for (int h = 0; h < HIST_DEPTH; h++) begin
                hist_valid_q[h] <= 1'b0;
                hist_tag_q[h]   <= '0;
                hist_data_q[h]  <= '0;
            end
        end else begin
            busy_q         <= busy_d;
            stall_cycles_q <= stall_cycles_d;
            for (int h = 0; h < HIST_DEPTH; h++) begin
                hist_valid_q[h] <= hist_valid_d[h];
                hist_tag_q[h]   <= hist_tag_d[h];
                hist_data_q[h]  <= hist_data_d[h];
            end
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
module tb_forward_scoreboard;

    localparam int TAG_W = 6;
    localparam int DW    = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_flush;
    logic           i_alloc_valid;
    logic [5:0]     i_alloc_tag;
    logic [1:0]     i_src_valid;
    logic [11:0]    i_src_tag;
    logic [63:0]    i_src_rf_data;
    logic [2:0]     i_fwd_valid;
    logic [2:0]     i_fwd_is_load;
    logic [17:0]    i_fwd_tag;
    logic [95:0]    i_fwd_data;
    logic           i_wb_valid;
    logic [5:0]     i_wb_tag;
    logic [31:0]    i_wb_data;
    logic [63:0]    o_src_data;
    logic [1:0]     o_src_ready;
    logic           o_stall;
    logic [6:0]     o_busy_count;
    logic [15:0]    o_stall_cycles;

    int checks = 0;
    int errors = 0;

    forward_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .i_flush        (i_flush),
        .i_alloc_valid  (i_alloc_valid),
        .i_alloc_tag    (i_alloc_tag),
        .i_src_valid    (i_src_valid),
        .i_src_tag      (i_src_tag),
        .i_src_rf_data  (i_src_rf_data),
        .i_fwd_valid    (i_fwd_valid),
        .i_fwd_is_load  (i_fwd_is_load),
        .i_fwd_tag      (i_fwd_tag),
        .i_fwd_data     (i_fwd_data),
        .i_wb_valid     (i_wb_valid),
        .i_wb_tag       (i_wb_tag),
        .i_wb_data      (i_wb_data),
        .o_src_data     (o_src_data),
        .o_src_ready    (o_src_ready),
        .o_stall        (o_stall),
        .o_busy_count   (o_busy_count),
        .o_stall_cycles (o_stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        i_flush       = 1'b0;
        i_alloc_valid = 1'b0;
        i_alloc_tag   = '0;
        i_src_valid   = '0;
        i_src_tag     = '0;
        i_src_rf_data = '0;
        i_fwd_valid   = '0;
        i_fwd_is_load = '0;
        i_fwd_tag     = '0;
        i_fwd_data    = '0;
        i_wb_valid    = 1'b0;
        i_wb_tag      = '0;
        i_wb_data     = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks sample 2 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic wb(input logic [5:0] tag, input logic [31:0] data);
        idle();
        i_wb_valid = 1'b1;
        i_wb_tag   = tag;
        i_wb_data  = data;
        tick();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        i_src_valid = 2'b11;
        i_src_tag   = {6'd4, 6'd3};
        settle();
        check("rst_busy",   32'(o_busy_count), 32'd0);
        check("rst_stall",  32'(o_stall), 32'd0);
        check("rst_ready",  32'(o_src_ready), 32'd3);
        check("rst_scnt",   32'(o_stall_cycles), 32'd0);
        tick();

        // Allocate 5, then read it with nothing forwarding it.
        idle();
        i_alloc_valid = 1'b1;
        i_alloc_tag   = 6'd5;
        tick();
        idle();
        i_src_valid = 2'b01;
        i_src_tag[5:0] = 6'd5;
        settle();
        check("busy_rdy0",  32'(o_src_ready[0]), 32'd0);
        check("busy_stall", 32'(o_stall), 32'd1);
        check("busy_cnt1",  32'(o_busy_count), 32'd1);
        tick();
        idle();
        settle();
        check("scnt_1",     32'(o_stall_cycles), 32'd1);

        // Priority among buses: bus 0 beats bus 2.
        i_src_valid    = 2'b01;
        i_src_tag[5:0] = 6'd5;
        i_fwd_valid    = 3'b101;
        i_fwd_tag      = {6'd5, 6'd0, 6'd5};
        i_fwd_data     = {32'h11, 32'h0, 32'h22};
        settle();
        check("fwd_pri_d",  o_src_data[31:0], 32'h22);
        check("fwd_pri_r",  32'(o_src_ready[0]), 32'd1);
        check("fwd_pri_st", 32'(o_stall), 32'd0);
        i_fwd_valid = 3'b100;
        settle();
        check("fwd2_d",     o_src_data[31:0], 32'h11);
        tick();

        // A load on bus 0 blocks the ready value on bus 1.
        idle();
        i_src_valid    = 2'b01;
        i_src_tag[5:0] = 6'd7;
        i_fwd_valid    = 3'b011;
        i_fwd_is_load  = 3'b001;
        i_fwd_tag      = {6'd0, 6'd7, 6'd7};
        i_fwd_data     = {32'h0, 32'h33, 32'h0};
        settle();
        check("load_rdy",   32'(o_src_ready[0]), 32'd0);
        check("load_stall", 32'(o_stall), 32'd1);
        tick();

        // Same-cycle write-back bypass, then history.
        idle();
        i_wb_valid     = 1'b1;
        i_wb_tag       = 6'd9;
        i_wb_data      = 32'hAB;
        i_src_valid    = 2'b01;
        i_src_tag[5:0] = 6'd9;
        settle();
        check("wb_byp_d",   o_src_data[31:0], 32'hAB);
        tick();
        idle();
        i_src_valid     = 2'b10;
        i_src_tag[11:6] = 6'd9;
        settle();
        check("hist_d",     o_src_data[63:32], 32'hAB);
        check("hist_r",     32'(o_src_ready[1]), 32'd1);
        tick();
        for (int t = 10; t <= 13; t++) wb(6'(t), 32'(t + 6));
        // History now holds 13,12,11,10; tag 9 has aged out.
        i_src_valid     = 2'b11;
        i_src_tag       = {6'd9, 6'd10};
        i_src_rf_data   = {32'hAB, 32'h0};
        settle();
        check("rf_d",       o_src_data[63:32], 32'hAB);
        check("rf_r",       32'(o_src_ready[1]), 32'd1);
        check("oldest_d",   o_src_data[31:0], 32'h10);
        i_src_rf_data   = {32'hCD, 32'h0};
        settle();
        check("aged_out",   o_src_data[63:32], 32'hCD);
        tick();

        // Alloc and write-back of tag 12 together: stays busy, no history hit.
        idle();
        i_alloc_valid = 1'b1;
        i_alloc_tag   = 6'd12;
        i_wb_valid    = 1'b1;
        i_wb_tag      = 6'd12;
        i_wb_data     = 32'h99;
        tick();
        idle();
        i_src_valid    = 2'b01;
        i_src_tag[5:0] = 6'd12;
        settle();
        check("aw_busy",    32'(o_busy_count), 32'd2);
        check("aw_rdy",     32'(o_src_ready[0]), 32'd0);
        tick();
        idle();
        settle();
        check("scnt_3",     32'(o_stall_cycles), 32'd3);

        // Write-back clears busy; tag 0 alloc is ignored.
        i_wb_valid    = 1'b1;
        i_wb_tag      = 6'd5;
        i_alloc_valid = 1'b1;
        i_alloc_tag   = 6'd0;
        tick();
        idle();
        settle();
        check("wb_clear",   32'(o_busy_count), 32'd1);

        // Saturation of the stall counter.
        i_src_valid    = 2'b01;
        i_src_tag[5:0] = 6'd12;
        repeat (65540) tick();
        idle();
        settle();
        check("scnt_sat",   32'(o_stall_cycles), 32'hFFFF);

        // Flush: busy and history gone, counter kept.
        i_flush       = 1'b1;
        i_alloc_valid = 1'b1;
        i_alloc_tag   = 6'd20;
        tick();
        idle();
        i_src_valid   = 2'b11;
        i_src_tag     = {6'd11, 6'd12};
        i_src_rf_data = {32'h77, 32'h0};
        settle();
        check("fl_busy",    32'(o_busy_count), 32'd0);
        check("fl_scnt",    32'(o_stall_cycles), 32'hFFFF);
        check("fl_rdy",     32'(o_src_ready), 32'd3);
        check("fl_hist",    o_src_data[63:32], 32'h77);
        tick();

        // Tag 0 ignores all buses.
        idle();
        i_src_valid    = 2'b01;
        i_src_tag[5:0] = 6'd0;
        i_src_rf_data  = {32'h0, 32'h55};
        i_fwd_valid    = 3'b111;
        i_fwd_is_load  = 3'b111;
        i_fwd_data     = {32'h1, 32'h2, 32'h3};
        i_wb_valid     = 1'b1;
        i_wb_data      = 32'h44;
        settle();
        check("z_d",        o_src_data[31:0], 32'h0);
        check("z_r",        32'(o_src_ready[0]), 32'd1);
        tick();

        // Reset mid-operation discards state and the reset-cycle inputs.
        idle();
        i_alloc_valid = 1'b1;
        i_alloc_tag   = 6'd3;
        tick();
        i_alloc_tag   = 6'd4;
        rst           = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        settle();
        check("mr_busy",    32'(o_busy_count), 32'd0);
        check("mr_scnt",    32'(o_stall_cycles), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
